// File: rtl/ita_package.sv
// Shared types and sizes for the activation pipeline.
package ita_package;

    // Number of parallel processing lanes
    localparam int unsigned N_PE = 16;

    // Width of the per-lane GELU polynomial product: 8-bit x times the
    // (q_clip + b)^2 + 2c term never exceeds 42 bits, so 48 leaves headroom.
    localparam int unsigned GELU_W = 48;

    typedef logic signed [7:0]  requant_t;
    typedef requant_t [N_PE-1:0] requant_oup_t;
    typedef logic [7:0]         requant_const_t;
    typedef logic signed [15:0] gelu_const_t;

    typedef enum logic [1:0] {
        Identity = 2'd0,
        Relu     = 2'd1,
        Gelu     = 2'd2
    } activation_e;

    typedef enum logic {
        Signed   = 1'b0,
        Unsigned = 1'b1
    } requant_mode_e;

endpackage

// File: rtl/gelu.sv
// One GELU lane: polynomial product (feeds stage 2) and requantisation with
// clipping (feeds stage 3). Purely combinational; the registers sit in the top.
module gelu
    import ita_package::*;
(
    input  requant_t                 data_i,
    input  gelu_const_t              b_i,
    input  gelu_const_t              c_i,
    output logic signed [GELU_W-1:0] poly_o,
    input  logic signed [GELU_W-1:0] poly_i,
    input  requant_const_t           requant_mult_i,
    input  requant_const_t           requant_shift_i,
    input  requant_t                 requant_add_i,
    input  requant_mode_e            requant_mode_i,
    output requant_t                 data_o
);

    // Clip a wide requantised value into the 8-bit output range of the mode;
    // Unsigned results are returned as their raw 8-bit pattern.
    function automatic requant_t saturate(input logic signed [63:0] v,
                                          input requant_mode_e      mode);
        if (mode == Unsigned) begin
            if (v < 64'sd0)   return 8'h00;
            if (v > 64'sd255) return 8'hFF;
            return requant_t'(v[7:0]);
        end
        if (v < -64'sd128) return -8'sd128;
        if (v > 64'sd127)  return 8'sd127;
        return requant_t'(v[7:0]);
    endfunction

    logic signed [GELU_W-1:0] x_w, abs_w, neg_b_w, clip_w, diff_w, l_w;
    logic signed [63:0]       prod_w, rnd_w, shr_w, sum_w;

    // Polynomial: L = sign(x)*((min(|x|,-b) + b)^2 + c), g = x*(L + c)
    always_comb begin
        x_w     = GELU_W'(data_i);
        neg_b_w = -GELU_W'(b_i);
        abs_w   = data_i[7] ? -x_w : x_w;
        clip_w  = (abs_w < neg_b_w) ? abs_w : neg_b_w;
        diff_w  = clip_w + GELU_W'(b_i);
        l_w     = diff_w * diff_w + GELU_W'(c_i);
        if (data_i[7]) begin
            l_w = -l_w;
        end
        poly_o  = x_w * (l_w + GELU_W'(c_i));
    end

    // Requantise with round-half-up before the arithmetic shift, then clip
    always_comb begin
        prod_w = 64'(poly_i) * $signed({56'd0, requant_mult_i});
        rnd_w  = (requant_shift_i == 8'd0) ? 64'sd0
                                           : (64'sd1 <<< (requant_shift_i - 8'd1));
        shr_w  = (prod_w + rnd_w) >>> requant_shift_i;
        sum_w  = shr_w + 64'(requant_add_i);
        data_o = saturate(sum_w, requant_mode_i);
    end

endmodule

// File: rtl/activation.sv
// Per-lane activation (Identity / Relu / Gelu) behind a 3-stage pipeline plus
// a registered output. Activation mode travels with its data vector.
module activation
    import ita_package::*;
#(
    parameter int unsigned N = N_PE
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  gelu_const_t           b_i,
    input  gelu_const_t           c_i,
    input  requant_t [N-1:0]      data_i,
    input  activation_e           activation_i,
    input  requant_mode_e         requant_mode_i,
    input  requant_const_t        requant_mult_i,
    input  requant_const_t        requant_shift_i,
    input  requant_t              requant_add_i,
    input  logic                  calc_en_i,
    input  logic                  calc_en_q_i,
    output requant_t [N-1:0]      data_o
);

    requant_t [N-1:0]              data_p1_q, data_p2_q, data_p3_q, data_o_q;
    logic     [N-1:0][GELU_W-1:0]  poly_d, poly_p2_q;
    requant_t [N-1:0]              gelu_d, gelu_p3_q, out_d;
    activation_e                   act_p1_q, act_p2_q, act_p3_q;

    // Lane datapaths: polynomial from stage-1 data, requant from stage-2 product
    for (genvar i = 0; i < N; i++) begin : g_lane
        gelu u_gelu (
            .data_i          (data_p1_q[i]),
            .b_i             (b_i),
            .c_i             (c_i),
            .poly_o          (poly_d[i]),
            .poly_i          (poly_p2_q[i]),
            .requant_mult_i  (requant_mult_i),
            .requant_shift_i (requant_shift_i),
            .requant_add_i   (requant_add_i),
            .requant_mode_i  (requant_mode_i),
            .data_o          (gelu_d[i])
        );
    end

    // Stage 1: capture input vector and its activation mode
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_p1_q <= '0;
            act_p1_q  <= Identity;
        end else if (calc_en_i) begin
            data_p1_q <= data_i;
            act_p1_q  <= activation_i;
        end
    end

    // Stages 2 and 3 plus the output register share the downstream enable
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_p2_q <= '0;
            poly_p2_q <= '0;
            act_p2_q  <= Identity;
            data_p3_q <= '0;
            gelu_p3_q <= '0;
            act_p3_q  <= Identity;
            data_o_q  <= '0;
        end else if (calc_en_q_i) begin
            data_p2_q <= data_p1_q;
            poly_p2_q <= poly_d;
            act_p2_q  <= act_p1_q;
            data_p3_q <= data_p2_q;
            gelu_p3_q <= gelu_d;
            act_p3_q  <= act_p2_q;
            data_o_q  <= out_d;
        end
    end

    // Output select: Identity and Relu bypass the requantiser entirely
    always_comb begin
        out_d = '0;
        for (int i = 0; i < int'(N); i++) begin
            unique case (act_p3_q)
                Gelu:    out_d[i] = gelu_p3_q[i];
                Relu:    out_d[i] = data_p3_q[i][7] ? 8'sd0 : data_p3_q[i];
                default: out_d[i] = data_p3_q[i];
            endcase
        end
    end

    assign data_o = data_o_q;

endmodule

// File: tb/tb_activation.sv
// Randomised and directed bench for activation against a queue-based model.
module tb_activation;
    import ita_package::*;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    gelu_const_t       b_i, c_i;
    requant_t [N_PE-1:0] data_i, data_o;
    activation_e       activation_i;
    requant_mode_e     requant_mode_i;
    requant_const_t    requant_mult_i, requant_shift_i;
    requant_t          requant_add_i;
    logic              calc_en_i, calc_en_q_i;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int x [N_PE];
        int act;
    } item_t;

    item_t       pend [$];
    logic [7:0]  exp_o [N_PE];

    always #5 clk_i = ~clk_i;

    activation dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .b_i             (b_i),
        .c_i             (c_i),
        .data_i          (data_i),
        .activation_i    (activation_i),
        .requant_mode_i  (requant_mode_i),
        .requant_mult_i  (requant_mult_i),
        .requant_shift_i (requant_shift_i),
        .requant_add_i   (requant_add_i),
        .calc_en_i       (calc_en_i),
        .calc_en_q_i     (calc_en_q_i),
        .data_o          (data_o)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, want);
        end
    endtask

    // Reference: the activation rules applied with plain 64-bit arithmetic
    function automatic logic [7:0] ref_lane(input int x, input int act);
        longint r, bb, cc, ax, qc, l, g;
        if (act == 0) begin
            r = x;
        end else if (act == 1) begin
            r = (x < 0) ? 0 : x;
        end else begin
            bb = b_i;
            cc = c_i;
            ax = (x < 0) ? -x : x;
            qc = (ax < -bb) ? ax : -bb;
            l  = (qc + bb) * (qc + bb) + cc;
            if (x < 0) l = -l;
            g  = x * (l + cc);
            r  = g * longint'(requant_mult_i);
            if (requant_shift_i > 0) r = r + (longint'(1) << (requant_shift_i - 1));
            r  = r >>> requant_shift_i;
            r  = r + longint'(requant_add_i);
            if (requant_mode_i == Signed) begin
                if (r < -128) r = -128;
                if (r > 127)  r = 127;
            end else begin
                if (r < 0)   r = 0;
                if (r > 255) r = 255;
            end
        end
        return r[7:0];
    endfunction

    function automatic item_t zero_item();
        item_t z;
        foreach (z.x[i]) z.x[i] = 0;
        z.act = 0;
        return z;
    endfunction

    // One clock: apply enables/reset, advance the model, check all lanes
    task automatic step(input bit en, input bit rst);
        item_t h, cur;
        calc_en_i   = en;
        calc_en_q_i = en;
        rst_ni      = ~rst;
        @(posedge clk_i);
        if (rst) begin
            pend.delete();
            repeat (3) pend.push_back(zero_item());
            foreach (exp_o[i]) exp_o[i] = 8'h00;
        end else if (en) begin
            h = pend.pop_front();
            foreach (exp_o[i]) exp_o[i] = ref_lane(h.x[i], h.act);
            foreach (cur.x[i]) cur.x[i] = int'(data_i[i]);
            cur.act = int'(activation_i);
            pend.push_back(cur);
        end
        #1;
        for (int i = 0; i < N_PE; i++) check($sformatf("out[%0d]", i), data_o[i], exp_o[i]);
    endtask

    task automatic flush();
        data_i       = '0;
        activation_i = Identity;
        repeat (3) step(1'b1, 1'b0);
    endtask

    // Issue one vector, flush it out and also check hand-computed results
    task automatic directed(input string tag, input activation_e a, input int v [4], input int e [4]);
        for (int i = 0; i < N_PE; i++) data_i[i] = requant_t'(v[i % 4]);
        activation_i = a;
        step(1'b1, 1'b0);
        flush();
        for (int i = 0; i < 4; i++) check($sformatf("%s[%0d]", tag, i), data_o[i], 8'(e[i]));
    endtask

    initial begin
        activation_e order [3] = '{Identity, Gelu, Relu};
        data_i          = '0;
        activation_i    = Identity;
        b_i             = -16'sd4;
        c_i             = 16'sd14;
        requant_mult_i  = 8'd1;
        requant_shift_i = 8'd0;
        requant_add_i   = 8'sd0;
        requant_mode_i  = Signed;
        calc_en_i       = 1'b0;
        calc_en_q_i     = 1'b0;
        rst_ni          = 1'b0;

        step(1'b0, 1'b1);
        step(1'b1, 1'b1);

        directed("ident", Identity, '{5, -7, -128, 127}, '{5, -7, -128, 127});
        directed("relu",  Relu,     '{-128, -1, 0, 127}, '{0, 0, 0, 127});
        directed("gelu",  Gelu,     '{0, 2, -2, 10},     '{0, 64, 8, 127});
        requant_shift_i = 8'd2;
        directed("gelu_sh2", Gelu,  '{2, 2, 2, 2},       '{16, 16, 16, 16});
        requant_shift_i = 8'd0;
        requant_mode_i  = Unsigned;
        directed("gelu_uns", Gelu,  '{10, 10, 10, 10},   '{255, 255, 255, 255});
        requant_mode_i  = Signed;

        for (int r = 0; r < 6; r++) begin
            flush();
            if (r > 0) begin
                b_i             = gelu_const_t'(-int'($urandom_range(1, 40)));
                c_i             = gelu_const_t'(int'($urandom_range(0, 100)) - 50);
                requant_mult_i  = 8'($urandom_range(0, 255));
                requant_shift_i = 8'($urandom_range(0, 10));
                requant_add_i   = requant_t'(int'($urandom_range(0, 255)) - 128);
                requant_mode_i  = requant_mode_e'($urandom_range(0, 1));
            end
            for (int c = 0; c < 40; c++) begin
                for (int i = 0; i < N_PE; i++) data_i[i] = requant_t'($urandom_range(0, 255));
                activation_i = order[c % 3];
                if (c == 15 || c == 16) step(1'b0, 1'b0);
                else if (c == 25 && r == 3) step(1'b1, 1'b1);
                else if (c == 25 && r == 4) step(1'b0, 1'b1);
                else step(1'b1, 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
